// File: rtl/sr_piso_eight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_piso_eight_pkg
//  Description : Shared constants and types for the PISO serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_piso_eight_pkg;

    // Default width of the parallel word and the shift register.
    localparam int PISO_WIDTH = 8;

    // Parallel word, indexed [PISO_WIDTH:1]; the top bit is serialized first.
    typedef logic [PISO_WIDTH:1] piso_word_t;

endpackage : sr_piso_eight_pkg
`default_nettype wire

// File: rtl/sr_piso_eight.sv
`default_nettype none
// ============================================================================
//  Module      : sr_piso_eight
//  Description : Parallel-in serial-out shift register. A write cycle loads
//                the parallel word; each later non-write cycle shifts it out
//                MSB first on q, with zero fill behind it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_piso_eight
    import sr_piso_eight_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic [WIDTH:1] inp,
    input  logic           clk,
    input  logic           reset,
    output logic           q,
    input  logic           write
);

    logic [WIDTH:1] r_sr;

    // Shift register: reset beats write, write beats shift; shift is a
    // left shift with zero fill so the register drains to all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr <= '0;
        end else if (write) begin
            r_sr <= inp;
        end else begin
            r_sr <= {r_sr[WIDTH-1:1], 1'b0};
        end
    end

    // Serial output comes straight from the register MSB, so q only
    // changes after a clock edge and never sees inp combinationally.
    assign q = r_sr[WIDTH];

endmodule : sr_piso_eight
`default_nettype wire

// File: tb/tb_sr_piso_eight.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_piso_eight
//  Description : Self-checking bench for sr_piso_eight at WIDTH=8 and
//                WIDTH=4, using a bit-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_piso_eight;
    import sr_piso_eight_pkg::*;

    logic       clk = 1'b0;
    piso_word_t in8;
    logic [4:1] in4;
    logic       rst8, wr8, q8;
    logic       rst4, wr4, q4;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the bits still to be presented on q, front first.
    bit m8[$];
    bit m4[$];

    always #5 clk = ~clk;

    sr_piso_eight #(.WIDTH(8)) dut8 (
        .inp   (in8),
        .clk   (clk),
        .reset (rst8),
        .q     (q8),
        .write (wr8)
    );

    sr_piso_eight #(.WIDTH(4)) dut4 (
        .inp   (in4),
        .clk   (clk),
        .reset (rst4),
        .q     (q4),
        .write (wr4)
    );

    // One clock edge: update the model from the values present at the edge,
    // then check both outputs 1ns later.
    task automatic tick(input string t);
        bit e8;
        bit e4;
        @(posedge clk);
        if (rst8) begin
            m8.delete();
        end else if (wr8) begin
            m8.delete();
            for (int i = 8; i >= 1; i--) m8.push_back(in8[i]);
        end else if (m8.size() > 0) begin
            void'(m8.pop_front());
        end
        if (rst4) begin
            m4.delete();
        end else if (wr4) begin
            m4.delete();
            for (int i = 4; i >= 1; i--) m4.push_back(in4[i]);
        end else if (m4.size() > 0) begin
            void'(m4.pop_front());
        end
        #1;
        e8 = (m8.size() > 0) ? m8[0] : 1'b0;
        e4 = (m4.size() > 0) ? m4[0] : 1'b0;
        n_assert++;
        assert (q8 === e8) else begin
            n_fail++;
            $error("FAIL %s w8 q observed=%b expected=%b", t, q8, e8);
        end
        n_assert++;
        assert (q4 === e4) else begin
            n_fail++;
            $error("FAIL %s w4 q observed=%b expected=%b", t, q4, e4);
        end
    endtask

    initial begin
        // Reset beats write on the first edge for both instances.
        rst8 = 1'b1; wr8 = 1'b1; in8 = 8'b11111111;
        rst4 = 1'b1; wr4 = 1'b1; in4 = 4'b1111;
        tick("reset_beats_write");
        n_assert++;
        assert (q8 === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_const q observed=%b expected=0", q8);
        end

        rst8 = 1'b0; wr8 = 1'b0;
        rst4 = 1'b0; wr4 = 1'b0;
        repeat (8) tick("idle_after_reset");

        // Load and serialize 10100001.
        wr8 = 1'b1; in8 = 8'b10100001;
        tick("load");
        wr8 = 1'b0; in8 = 8'h00;
        repeat (9) tick("serialize");

        // Continuous load: q follows the MSB sampled at each edge.
        wr8 = 1'b1; in8 = 8'b00100010; tick("cont_load0");
        in8 = 8'b10100001;             tick("cont_load1");
        in8 = 8'b01101111;             tick("cont_load2");
        n_assert++;
        assert (q8 === 1'b0) else begin
            n_fail++;
            $error("FAIL cont_load_const q observed=%b expected=0", q8);
        end
        wr8 = 1'b0;

        // Reload mid-shift discards the remaining bits.
        wr8 = 1'b1; in8 = 8'b11110000; tick("reload_first");
        wr8 = 1'b0;
        repeat (3) tick("reload_shift");
        wr8 = 1'b1; in8 = 8'b00001111; tick("reload_second");
        wr8 = 1'b0;
        repeat (8) tick("reload_drain");

        // Reset mid-shift clears the register.
        wr8 = 1'b1; in8 = 8'b11111111; tick("rst_mid_load");
        wr8 = 1'b0;
        repeat (2) tick("rst_mid_shift");
        rst8 = 1'b1; tick("rst_mid_reset");
        rst8 = 1'b0;
        repeat (3) tick("rst_mid_after");

        // Narrow instance: 1001 serializes as 1,0,0,1 then 0.
        wr4 = 1'b1; in4 = 4'b1001; tick("w4_load");
        wr4 = 1'b0;
        repeat (5) tick("w4_shift");

        // Randomized traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            rst8 = ($urandom_range(0, 31) == 0);
            wr8  = ($urandom_range(0, 3) == 0);
            in8  = piso_word_t'($urandom);
            rst4 = ($urandom_range(0, 31) == 0);
            wr4  = ($urandom_range(0, 4) == 0);
            in4  = 4'($urandom);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sr_piso_eight
`default_nettype wire

// File: doc/sr_piso_eight.md
Name: sr_piso_eight

Overview:
- Parallel-in serial-out (PISO) shift register, default 8 bits wide.
- A parallel word is loaded on a write cycle. On every later non-write cycle the word shifts out one bit per clock, MSB first, on a single serial output.
- Used as a serializer between a byte-wide producer and a 1-bit serial link.

Parameters:
- WIDTH, 8, number of bits in the parallel word and the shift register (minimum 2).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- inp  input  WIDTH  parallel load word, indexed [WIDTH:1]; inp[WIDTH] is the MSB and the first bit serialized.
- q  output  1  serial data out; always equals the MSB of the internal shift register.
- write  input  1  parallel-load strobe; when high at a rising edge, the register loads inp.
- Port order for positional instantiation: inp, clk, reset, q, write.

Behaviour:
- State: one WIDTH-bit register sr[WIDTH:1]; no other state is required.
- Output: q = sr[WIDTH], driven combinationally from the register (register-to-output, no logic on inp). q changes only after a rising clk edge.
- Priority at each rising edge of clk: reset, then write, then shift.
- reset=1: sr <= 0, so q=0 from the next edge. Overrides write. Asynchronous assertion has no effect until the next edge.
- reset=0, write=1: sr <= inp. q shows inp[WIDTH] immediately after that edge.
- reset=0, write=0: sr <= {sr[WIDTH-1:1], 1'b0}, a left shift with zero fill. Successive edges present the original inp[WIDTH], inp[WIDTH-1], ..., inp[1] on q.
- After WIDTH shift edges, sr is all zeros and q stays 0 until the next write.
- Latency: the first serial bit is valid 1 cycle after the load edge; bit k (k=0 is the MSB) is valid k cycles after that.
- Write during an active shift: the new word replaces the register contents. No completion handshake, and the untransmitted bits are discarded.
- Continuous write=1: the register reloads every edge, so q tracks inp[WIDTH] as sampled at each edge.
- Power-up: the register is undefined until the first reset or write edge. The bench must apply reset or write before checking q.
- Input sampling: inp and write are sampled only at the rising edge. The bench must change them away from the clock edge to avoid races.

Decomposition:
- Shared package: the default width constant (PISO_WIDTH = 8) and a typedef for the parallel word (logic [PISO_WIDTH:1]).
- No sub-module is needed. Implement as a single always_ff with the priority chain above, plus a continuous assignment for q.

Test Plan:
- Reset: drive reset=1, write=1, inp=8'b11111111 for one edge -> q=0 after the edge (reset beats write). Release reset with write=0 -> q stays 0 for 8 edges.
- Load and serialize: write=1, inp=8'b10100001 for one edge, then write=0 -> q sequence over the following edges = 1,0,1,0,0,0,0,1, then 0 thereafter.
- Continuous load: write=1 held, inp stepped 8'b00100010, 8'b10100001, 8'b01101111 (changed mid-cycle) -> q after each edge = 0, 1, 0 (MSB of the word sampled at that edge).
- Reload mid-shift: load 8'b11110000, shift 3 edges (q=1,1,1), then write 8'b00001111 -> q=0 after the load edge, followed by 0,0,0,1,1,1,1 on subsequent shift edges.
- Reset mid-shift: load 8'b11111111, shift 2 edges, assert reset for one edge -> q=0 immediately after the reset edge. Further shifts with write=0 keep q=0.
- Parameter check: instantiate with WIDTH=4, load 4'b1001 -> q = 1,0,0,1 then 0.
